// File: rtl/periodic_pipe_register.sv
// Decimated delay line: DEPTH-stage register advancing once every PERIOD enabled cycles.
// Latency is DEPTH ticks including the capturing one; no backpressure, en/sync only gate the tick.
module periodic_pipe_register #(
    parameter int             W         = 8,
    parameter int             DEPTH     = 3,
    parameter int             PERIOD    = 3,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          flush,
    input  logic [W-1:0]  d,
    output logic          tick,
    output logic [W-1:0]  q,
    output logic          q_valid
);

    localparam int            CW   = $clog2((PERIOD > 1) ? PERIOD : 2);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_stage [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = en & ~sync & ~rst & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (sync) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // Flush wins over a coincident tick so the sample on d is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
                r_vld[i]   <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
                r_vld[i]   <= 1'b0;
            end
        end else if (tick) begin
            r_stage[0] <= d;
            r_vld[0]   <= 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
                r_vld[i]   <= r_vld[i-1];
            end
        end
    end

    assign q       = r_stage[DEPTH-1];
    assign q_valid = r_vld[DEPTH-1];

endmodule
